// File: rtl/led_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// led_pulse_stretcher
//
// Turns single-cycle LED strobes from the heartbeat blinker into visible
// flashes. Each accepted rising edge of trig lights the LED solidly for
// HOLD_CYCLES clocks and then fades it out with 8-bit PWM, one brightness
// step every STEP_CYCLES clocks. A new edge during a flash restarts it from
// the solid-on phase.
//
// Parameters
//   HOLD_CYCLES : solid-on time per flash in clocks (>= 1)
//   STEP_CYCLES : clocks per brightness decrement during the fade (>= 1)
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   enable    in   block enable; low forces idle and ignores trig
//   trig      in   strobe input, only its rising edge counts
//   led_out   out  registered LED drive
//   busy      out  high while a flash is in progress
//   level     out  current brightness (255 hold, fading, 0 idle)
//   evt_count out  accepted trigger edges, wraps 65535 -> 0
// -----------------------------------------------------------------------------
module led_pulse_stretcher #(
    parameter int unsigned HOLD_CYCLES = 32'd12500000,
    parameter int unsigned STEP_CYCLES = 32'd48828
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        trig,
    output logic        led_out,
    output logic        busy,
    output logic [7:0]  level,
    output logic [15:0] evt_count
);

    // Flash phases; the unused encoding is steered back to idle.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_FADE = 2'd2;

    // Terminal counts: the counters start at 0 on phase entry.
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 32'd1);
    localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES - 32'd1);

    localparam logic [7:0] LEVEL_FULL = 8'd255;
    localparam logic [7:0] LEVEL_OFF  = 8'd0;

    logic        trig_d_r;
    logic [7:0]  pwm_cnt_r;
    logic [1:0]  state_r;
    logic [31:0] hold_cnt_r;
    logic [31:0] step_cnt_r;
    logic [7:0]  level_r;
    logic [15:0] evt_count_r;
    logic        led_out_r;

    logic        edge_s;
    logic        hold_done_s;
    logic        step_done_s;
    logic [1:0]  state_nxt_s;
    logic [31:0] hold_cnt_nxt_s;
    logic [31:0] step_cnt_nxt_s;
    logic [7:0]  level_nxt_s;
    logic [15:0] evt_count_nxt_s;
    logic        led_out_nxt_s;

    // Accepted trigger: rising edge of trig while enabled.
    assign edge_s      = trig & ~trig_d_r & enable;
    assign hold_done_s = (hold_cnt_r == HOLD_LAST);
    assign step_done_s = (step_cnt_r == STEP_LAST);

    // Flash sequencer next-state logic: idle -> hold -> fade -> idle.
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        step_cnt_nxt_s = step_cnt_r;
        level_nxt_s    = level_r;

        if (!enable) begin
            // Disable wins over everything, including a pending step.
            state_nxt_s    = ST_IDLE;
            hold_cnt_nxt_s = 32'd0;
            step_cnt_nxt_s = 32'd0;
            level_nxt_s    = LEVEL_OFF;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hold_cnt_nxt_s = 32'd0;
                    step_cnt_nxt_s = 32'd0;
                    if (edge_s) begin
                        state_nxt_s = ST_HOLD;
                        level_nxt_s = LEVEL_FULL;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        level_nxt_s = LEVEL_OFF;
                    end
                end

                ST_HOLD: begin
                    level_nxt_s = LEVEL_FULL;
                    if (edge_s) begin
                        // Retrigger restarts the solid-on window.
                        hold_cnt_nxt_s = 32'd0;
                    end else if (hold_done_s) begin
                        state_nxt_s    = ST_FADE;
                        hold_cnt_nxt_s = 32'd0;
                        step_cnt_nxt_s = 32'd0;
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r + 32'd1;
                    end
                end

                ST_FADE: begin
                    if (edge_s) begin
                        // A new edge beats a coincident fade step.
                        state_nxt_s    = ST_HOLD;
                        level_nxt_s    = LEVEL_FULL;
                        hold_cnt_nxt_s = 32'd0;
                        step_cnt_nxt_s = 32'd0;
                    end else if (step_done_s) begin
                        step_cnt_nxt_s = 32'd0;
                        // <= 1 also catches a corrupted zero level so it
                        // cannot wrap back to full brightness.
                        if (level_r <= 8'd1) begin
                            level_nxt_s = LEVEL_OFF;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            level_nxt_s = level_r - 8'd1;
                        end
                    end else begin
                        step_cnt_nxt_s = step_cnt_r + 32'd1;
                    end
                end

                default: begin
                    state_nxt_s    = ST_IDLE;
                    hold_cnt_nxt_s = 32'd0;
                    step_cnt_nxt_s = 32'd0;
                    level_nxt_s    = LEVEL_OFF;
                end
            endcase
        end
    end

    // Event counter next value; wraps naturally at 16 bits.
    always_comb begin
        if (edge_s) begin
            evt_count_nxt_s = evt_count_r + 16'd1;
        end else begin
            evt_count_nxt_s = evt_count_r;
        end
    end

    // LED drive decoded from the current state, registered one cycle later.
    always_comb begin
        case (state_r)
            ST_HOLD: led_out_nxt_s = 1'b1;
            ST_FADE: led_out_nxt_s = (pwm_cnt_r < level_r);
            default: led_out_nxt_s = 1'b0;
        endcase
    end

    // Trigger delay register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_d_r <= 1'b0;
        end else begin
            trig_d_r <= trig;
        end
    end

    // Free-running PWM phase counter; never stalls, wraps 255 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= 8'd0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end
    end

    // Sequencer state, timing counters and brightness level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 32'd0;
            step_cnt_r <= 32'd0;
            level_r    <= LEVEL_OFF;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            step_cnt_r <= step_cnt_nxt_s;
            level_r    <= level_nxt_s;
        end
    end

    // Accepted-event counter; survives enable drops, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_count_r <= 16'd0;
        end else begin
            evt_count_r <= evt_count_nxt_s;
        end
    end

    // Registered LED output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out_r <= 1'b0;
        end else begin
            led_out_r <= led_out_nxt_s;
        end
    end

    assign led_out   = led_out_r;
    assign busy      = (state_r != ST_IDLE);
    assign level     = level_r;
    assign evt_count = evt_count_r;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// Testbench for led_pulse_stretcher (HOLD_CYCLES=4, STEP_CYCLES=2).
// Expectations are pushed into a queue as stimulus is applied and popped and
// compared once the clock edge that produces them has passed.
// -----------------------------------------------------------------------------
module tb_led_pulse_stretcher;

    localparam int H     = 4;
    localparam int S     = 2;
    localparam int FLASH = H + 255 * S;

    localparam int SEL_LED   = 0;
    localparam int SEL_BUSY  = 1;
    localparam int SEL_LEVEL = 2;
    localparam int SEL_EVT   = 3;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        enable = 1'b0;
    logic        trig   = 1'b0;
    logic        led_out;
    logic        busy;
    logic [7:0]  level;
    logic [15:0] evt_count;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_passed = 0;
    logic [7:0]  pwm_m;
    logic [15:0] exp_evt = 16'd0;

    led_pulse_stretcher #(
        .HOLD_CYCLES(H),
        .STEP_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .trig      (trig),
        .led_out   (led_out),
        .busy      (busy),
        .level     (level),
        .evt_count (evt_count)
    );

    always #5 clk = ~clk;

    // Reference PWM phase: counts clock edges since the last reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_m <= 8'd0;
        else        pwm_m <= pwm_m + 8'd1;
    end

    // j = cycles since the last accepted edge (edge itself is j = 0).
    function automatic bit m_busy(input int j);
        return (j >= 0) && (j < FLASH);
    endfunction

    function automatic int m_level(input int j);
        if (!m_busy(j)) return 0;
        if (j < H)      return 255;
        return 255 - (j - H) / S;
    endfunction

    // LED after an edge reflects the state one cycle earlier (jp).
    function automatic bit m_led(input int jp, input logic [7:0] pwm_b);
        if (!m_busy(jp)) return 1'b0;
        if (jp < H)      return 1'b1;
        return ({24'd0, pwm_b} < 32'(m_level(jp)));
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input string tag);
        push({tag, "_led"},   SEL_LED,   32'd0);
        push({tag, "_busy"},  SEL_BUSY,  32'd0);
        push({tag, "_level"}, SEL_LEVEL, 32'd0);
        push({tag, "_evt"},   SEL_EVT,   32'(exp_evt));
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_LED:   obs = {31'd0, led_out};
                SEL_BUSY:  obs = {31'd0, busy};
                SEL_LEVEL: obs = {24'd0, level};
                SEL_EVT:   obs = {16'd0, evt_count};
                default:   obs = 32'hxxxx_xxxx;
            endcase
            n_checks++;
            assert (obs === e.exp) n_passed++;
            else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One flash from idle with optional retrigger edge index and early stop.
    task automatic flash(input string tag, input int retrig_at, input int stop_at,
                         input int exp_busy_total);
        int         last     = -100000;
        int         busy_cnt = 0;
        int         jp;
        int         j;
        logic [7:0] pwm_b;
        for (int i = 0; i < 3000; i++) begin
            trig  = (i == 0) || (i == retrig_at);
            jp    = (i - 1) - last;
            pwm_b = pwm_m;
            if (trig) begin
                last = i;
                exp_evt++;
            end
            j = i - last;
            push({tag, "_busy"},  SEL_BUSY,  32'(m_busy(j)));
            push({tag, "_level"}, SEL_LEVEL, 32'(m_level(j)));
            push({tag, "_led"},   SEL_LED,   32'(m_led(jp, pwm_b)));
            push({tag, "_evt"},   SEL_EVT,   32'(exp_evt));
            tick();
            check_all();
            if (busy === 1'b1) busy_cnt++;
            if (i == stop_at) break;
            if (i > 0 && !m_busy(jp) && !m_busy(j)) break;
        end
        trig = 1'b0;
        if (exp_busy_total >= 0) begin
            n_checks++;
            assert (busy_cnt == exp_busy_total) n_passed++;
            else $error("FAIL %s_busy_len observed=%0d expected=%0d", tag, busy_cnt, exp_busy_total);
        end
    endtask

    initial begin
        // Reset values while rst_n is held low.
        #12;
        push_idle("reset");
        check_all();
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();

        // Single flash, no retrigger.
        flash("single", -1, -1, FLASH);

        // Retrigger two cycles into HOLD: busy extends by two cycles.
        flash("rehold", 2, -1, FLASH + 2);

        // Retrigger while level is 100 (previous edge showed 100).
        flash("refade", H + 311, -1, H + 311 + FLASH);

        // Enable drop in FADE at level 240.
        flash("pre_dis", -1, H + 30, -1);
        begin
            logic [7:0] pwm_b;
            enable = 1'b0;
            pwm_b  = pwm_m;
            push("dis_busy",  SEL_BUSY,  32'd0);
            push("dis_level", SEL_LEVEL, 32'd0);
            push("dis_led",   SEL_LED,   32'(m_led(H + 30, pwm_b)));
            push("dis_evt",   SEL_EVT,   32'(exp_evt));
            tick();
            check_all();
        end
        push_idle("dis_next");
        tick();
        check_all();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        push_idle("dis_trig");
        check_all();
        enable = 1'b1;
        tick();

        // Trigger held high for 20 cycles: a single event.
        trig = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 0) exp_evt++;
            push("held_evt", SEL_EVT, 32'(exp_evt));
            tick();
            check_all();
        end
        trig = 1'b0;
        tick();

        // Back-to-back short pulses, one event each.
        for (int k = 0; k < 300; k++) begin
            trig = 1'b1;
            tick();
            trig = 1'b0;
            tick();
        end
        exp_evt = exp_evt + 16'd300;
        push("pulses_evt", SEL_EVT, 32'(exp_evt));
        check_all();

        // Preload the counter near the top, then pulse across the wrap.
        force dut.evt_count_r = 16'hFFFE;
        #1;
        release dut.evt_count_r;
        exp_evt = 16'hFFFE;
        push("preload_evt", SEL_EVT, 32'(exp_evt));
        check_all();
        trig = 1'b1;
        exp_evt++;
        push("top_evt", SEL_EVT, 32'(exp_evt));
        tick();
        check_all();
        trig = 1'b0;
        tick();
        trig = 1'b1;
        exp_evt++;
        push("wrap_evt", SEL_EVT, 32'(exp_evt));
        tick();
        check_all();
        trig = 1'b0;

        // Asynchronous reset mid-flash, checked before any clock edge.
        tick();
        tick();
        #2;
        rst_n   = 1'b0;
        exp_evt = 16'd0;
        #1;
        push_idle("async_rst");
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        push_idle("post_rst");
        check_all();

        // Normal flash after reset; counter restarts from zero.
        flash("after_rst", -1, -1, FLASH);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
